aurora_init_ctrl: RTL and testbench

Simplex TX initialization sequencer for the multi-lane encoder datapath.
- Walks the channel through reset, lane alignment, channel bonding and verification, then opens the AXI data path.
- Drives a per-lane command and lane-enable mask to the lane encoders, driven by the simplex_* sideband status.
- Sits between the AXI source and the lane encoders inside aurora_top.

---
 rtl/aurora_pkg.sv | 46 ++++
 rtl/aurora_init_timer.sv | 28 ++
 rtl/aurora_init_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_aurora_init_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// aurora_pkg: shared lane-count constants, encoder command and init-state
// encodings, and small helpers used by the aurora TX datapath.
package aurora_pkg;

  // Number of physical lanes and the width of a lane index.
  localparam int MAX_LINKS      = 4;
  localparam int MAX_LINKS_SIZE = (MAX_LINKS > 1) ? $clog2(MAX_LINKS) : 1;

  // Command broadcast to the lane encoders.
  typedef enum logic [2:0] {
    CMD_RESET  = 3'd0,
    CMD_ALIGN  = 3'd1,
    CMD_BOND   = 3'd2,
    CMD_VERIFY = 3'd3,
    CMD_DATA   = 3'd4
  } tx_cmd_t;

  // Phases of the TX initialization sequence.
  typedef enum logic [2:0] {
    RESET,
    ALIGN,
    BOND,
    VERIFY,
    READY
  } init_state_t;

  // Encoder command issued while the sequencer sits in a given phase.
  function automatic tx_cmd_t state_cmd(input init_state_t s);
    tx_cmd_t c;
    case (s)
      RESET:   c = CMD_RESET;
      ALIGN:   c = CMD_ALIGN;
      BOND:    c = CMD_BOND;
      VERIFY:  c = CMD_VERIFY;
      READY:   c = CMD_DATA;
      default: c = CMD_RESET;
    endcase
    return c;
  endfunction

  // Larger of two integers, used for sizing counters from parameters.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aurora_init_timer.sv
// aurora_init_timer: saturating up-counter with synchronous clear.
// Counts every cycle, sticks at all-ones instead of wrapping, and returns
// to zero on the cycle after clear is high.
module aurora_init_timer
  import aurora_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

  // Count up each cycle, hold at the ceiling, zero on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != COUNT_MAX) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/aurora_init_ctrl.sv
// aurora_init_ctrl: simplex TX initialization sequencer.
// Steps the channel RESET -> ALIGN -> (BOND) -> VERIFY -> READY using the
// simplex_* sideband status, drives the lane encoder command and lane enable
// mask, and opens the AXI path once the channel is up.
// Optional build macro AURORA_INIT_TIMEOUT_EN adds a per-phase watchdog that
// forces re-initialization and pulses init_timeout; without it init_timeout
// is tied low and the init phases wait indefinitely.
module aurora_init_ctrl
  import aurora_pkg::*;
#(
  parameter int RESET_CYCLES     = 16,
  parameter int MIN_ALIGN_CYCLES = 64,
  parameter int VERIFY_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES   = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      single_lane,
  input  logic [MAX_LINKS_SIZE-1:0] lane_select,
  input  logic                      simplex_aligned,
  input  logic                      simplex_bonded,
  input  logic                      simplex_verified,
  input  logic                      simplex_reset,
  input  logic                      axi_valid,
  input  logic                      axi_last,
  output logic                      axi_ready,
  output tx_cmd_t                   tx_cmd,
  output logic [MAX_LINKS-1:0]      lane_en,
  output logic                      channel_up,
  output logic                      frame_abort,
  output logic                      init_timeout
);

  // Counters are sized from the largest cycle parameter so that every
  // threshold is representable; they saturate rather than wrap.
  localparam int MAX_PARAM = max_int(max_int(RESET_CYCLES, MIN_ALIGN_CYCLES),
                                     max_int(VERIFY_CYCLES, TIMEOUT_CYCLES));
  localparam int CW = $clog2(MAX_PARAM) + 1;

  localparam logic [CW-1:0] RESET_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] ALIGN_LAST  = CW'(MIN_ALIGN_CYCLES - 1);
  localparam logic [CW-1:0] VERIFY_LAST = CW'(VERIFY_CYCLES - 1);

  init_state_t          state;
  init_state_t          next_state;
  logic [CW-1:0]        phase_count;
  logic                 phase_clear;
  logic                 state_change;
  logic                 single_latched;
  logic                 in_frame;
  logic                 beat_accept;
  logic                 leave_ready;
  logic                 timeout_hit;
  logic [MAX_LINKS-1:0] lane_mask;

  assign state_change = (next_state != state);
  // While the receiver keeps requesting reset, the RESET dwell restarts.
  assign phase_clear  = state_change || ((state == RESET) && simplex_reset);
  assign beat_accept  = (state == READY) && axi_valid;
  assign leave_ready  = (state == READY) && (next_state != READY);
  assign lane_mask    = single_lane ? (MAX_LINKS'(1) << lane_select)
                                    : {MAX_LINKS{1'b1}};

  aurora_init_timer #(
    .WIDTH (CW)
  ) u_phase_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (phase_clear),
    .count (phase_count)
  );

`ifdef AURORA_INIT_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_count;
  logic          wd_clear;
  logic          in_init_phase;
  logic          wd_expired;

  // The watchdog only runs inside ALIGN/BOND/VERIFY and restarts per phase.
  assign in_init_phase = (state == ALIGN) || (state == BOND) || (state == VERIFY);
  assign wd_clear      = state_change || !in_init_phase;
  assign wd_expired    = in_init_phase && (wd_count == TIMEOUT_LAST);

  aurora_init_timer #(
    .WIDTH (CW)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wd_clear),
    .count (wd_count)
  );
`endif

  // Next-phase selection: receiver reset, loss of alignment, watchdog, then
  // the normal forward progression.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    if ((state != RESET) && simplex_reset) begin
      next_state = RESET;
    end else if (((state == BOND) || (state == VERIFY) || (state == READY)) &&
                 !simplex_aligned) begin
      next_state = RESET;
    end
`ifdef AURORA_INIT_TIMEOUT_EN
    else if (wd_expired) begin
      next_state  = RESET;
      timeout_hit = 1'b1;
    end
`endif
    else begin
      case (state)
        RESET: begin
          if (!simplex_reset && (phase_count == RESET_LAST)) begin
            next_state = ALIGN;
          end
        end
        ALIGN: begin
          if ((phase_count >= ALIGN_LAST) && simplex_aligned) begin
            next_state = single_latched ? VERIFY : BOND;
          end
        end
        BOND: begin
          if (simplex_bonded) begin
            next_state = VERIFY;
          end
        end
        VERIFY: begin
          if ((phase_count >= VERIFY_LAST) && simplex_verified) begin
            next_state = READY;
          end
        end
        READY: begin
          next_state = READY;
        end
        default: begin
          next_state = RESET;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next phase so they change
  // on the same edge as the state; also lane config latch and frame tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RESET;
      tx_cmd         <= CMD_RESET;
      axi_ready      <= 1'b0;
      channel_up     <= 1'b0;
      frame_abort    <= 1'b0;
      lane_en        <= '0;
      single_latched <= 1'b0;
      in_frame       <= 1'b0;
`ifdef AURORA_INIT_TIMEOUT_EN
      init_timeout   <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      tx_cmd      <= state_cmd(next_state);
      axi_ready   <= (next_state == READY);
      channel_up  <= (next_state == READY);
      frame_abort <= leave_ready && (in_frame || (axi_valid && !axi_last));
`ifdef AURORA_INIT_TIMEOUT_EN
      init_timeout <= timeout_hit;
`endif
      if ((state == RESET) && (next_state == ALIGN)) begin
        lane_en        <= lane_mask;
        single_latched <= single_lane;
      end
      if (leave_ready) begin
        in_frame <= 1'b0;
      end else if (beat_accept) begin
        in_frame <= !axi_last;
      end
    end
  end

`ifndef AURORA_INIT_TIMEOUT_EN
  assign init_timeout = 1'b0;
  // timeout_hit stays low in this build; fold it into a harmless reduction.
  logic unused_timeout;
  assign unused_timeout = timeout_hit;
`endif

endmodule

// File: tb/tb_aurora_init_ctrl.sv
// tb_aurora_init_ctrl: directed bench for aurora_init_ctrl with a phase-level
// reference model compared every cycle, plus hand-computed cycle checkpoints.
// Honors AURORA_INIT_TIMEOUT_EN to select the watchdog expectations.
module tb_aurora_init_ctrl;
  import aurora_pkg::*;

  localparam int RST_CYC = 16;
  localparam int ALN_CYC = 64;
  localparam int VER_CYC = 64;
  localparam int TMO_CYC = 200;

  logic                      clk;
  logic                      rst_n;
  logic                      single_lane;
  logic [MAX_LINKS_SIZE-1:0] lane_select;
  logic                      simplex_aligned;
  logic                      simplex_bonded;
  logic                      simplex_verified;
  logic                      simplex_reset;
  logic                      axi_valid;
  logic                      axi_last;
  logic                      axi_ready;
  tx_cmd_t                   tx_cmd;
  logic [MAX_LINKS-1:0]      lane_en;
  logic                      channel_up;
  logic                      frame_abort;
  logic                      init_timeout;

  int vectors;
  int miscompares;
  int cyc;
  bit check_en;
  bit saw_bond;
  bit saw_timeout;

  aurora_init_ctrl #(
    .RESET_CYCLES     (RST_CYC),
    .MIN_ALIGN_CYCLES (ALN_CYC),
    .VERIFY_CYCLES    (VER_CYC),
    .TIMEOUT_CYCLES   (TMO_CYC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .single_lane      (single_lane),
    .lane_select      (lane_select),
    .simplex_aligned  (simplex_aligned),
    .simplex_bonded   (simplex_bonded),
    .simplex_verified (simplex_verified),
    .simplex_reset    (simplex_reset),
    .axi_valid        (axi_valid),
    .axi_last         (axi_last),
    .axi_ready        (axi_ready),
    .tx_cmd           (tx_cmd),
    .lane_en          (lane_en),
    .channel_up       (channel_up),
    .frame_abort      (frame_abort),
    .init_timeout     (init_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles since the latest reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model: phase name plus cycles spent in it.
  typedef enum int {P_RESET, P_ALIGN, P_BOND, P_VERIFY, P_READY} phase_e;
`ifdef AURORA_INIT_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  phase_e     m_phase;
  int         m_dwell;
  logic [3:0] m_lane_en;
  bit         m_single;
  bit         m_in_frame;
  bit         m_abort;
  bit         m_tmo;

  always @(posedge clk or negedge rst_n) begin
    phase_e nxt;
    bit     tmo;
    if (!rst_n) begin
      m_phase    = P_RESET;
      m_dwell    = 0;
      m_lane_en  = 4'b0000;
      m_single   = 1'b0;
      m_in_frame = 1'b0;
      m_abort    = 1'b0;
      m_tmo      = 1'b0;
    end else begin
      nxt = m_phase;
      tmo = 1'b0;
      if (m_phase != P_RESET && simplex_reset)
        nxt = P_RESET;
      else if ((m_phase == P_BOND || m_phase == P_VERIFY || m_phase == P_READY) && !simplex_aligned)
        nxt = P_RESET;
      else if (WD_ON && (m_phase == P_ALIGN || m_phase == P_BOND || m_phase == P_VERIFY) &&
               (m_dwell + 1 == TMO_CYC)) begin
        nxt = P_RESET;
        tmo = 1'b1;
      end else begin
        case (m_phase)
          P_RESET:  if (!simplex_reset && m_dwell + 1 == RST_CYC) nxt = P_ALIGN;
          P_ALIGN:  if (simplex_aligned && m_dwell + 1 >= ALN_CYC) nxt = m_single ? P_VERIFY : P_BOND;
          P_BOND:   if (simplex_bonded) nxt = P_VERIFY;
          P_VERIFY: if (simplex_verified && m_dwell + 1 >= VER_CYC) nxt = P_READY;
          default:  nxt = m_phase;
        endcase
      end
      m_abort = (m_phase == P_READY) && (nxt != P_READY) &&
                (m_in_frame || (axi_valid && !axi_last));
      if (m_phase == P_READY && nxt != P_READY) m_in_frame = 1'b0;
      else if (m_phase == P_READY && axi_valid) m_in_frame = !axi_last;
      if (m_phase == P_RESET && nxt == P_ALIGN) begin
        m_single  = single_lane;
        m_lane_en = single_lane ? (4'b0001 << lane_select) : 4'b1111;
      end
      m_tmo = tmo;
      if (nxt != m_phase || (m_phase == P_RESET && simplex_reset)) m_dwell = 0;
      else m_dwell = m_dwell + 1;
      m_phase = nxt;
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int model_cmd(input phase_e p);
    case (p)
      P_RESET:  return 0;
      P_ALIGN:  return 1;
      P_BOND:   return 2;
      P_VERIFY: return 3;
      default:  return 4;
    endcase
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check_output("tx_cmd",       int'(tx_cmd),       model_cmd(m_phase));
      check_output("axi_ready",    int'(axi_ready),    int'(m_phase == P_READY));
      check_output("channel_up",   int'(channel_up),   int'(m_phase == P_READY));
      check_output("lane_en",      int'(lane_en),      int'(m_lane_en));
      check_output("frame_abort",  int'(frame_abort),  int'(m_abort));
      check_output("init_timeout", int'(init_timeout), int'(m_tmo));
      if (tx_cmd == CMD_BOND) saw_bond = 1'b1;
      if (init_timeout)       saw_timeout = 1'b1;
    end
  end

  task automatic apply_stimulus(input bit single, input int sel, input bit aligned,
                                input bit bonded, input bit verified, input bit sreset);
    single_lane      = single;
    lane_select      = MAX_LINKS_SIZE'(sel);
    simplex_aligned  = aligned;
    simplex_bonded   = bonded;
    simplex_verified = verified;
    simplex_reset    = sreset;
    axi_valid        = 1'b0;
    axi_last         = 1'b0;
  endtask

  task automatic do_reset(input bit single, input int sel, input bit aligned,
                          input bit bonded, input bit verified);
    #1 rst_n = 1'b0;
    apply_stimulus(single, sel, aligned, bonded, verified, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    saw_bond    = 1'b0;
    saw_timeout = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached at cyc %0d", cyc);
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    rst_n       = 1'b0;
    apply_stimulus(1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check_en = 1'b1;

    // Single lane 2, receiver already aligned/verified.
    do_reset(1'b1, 2, 1'b1, 1'b0, 1'b1);
    wait_cyc(15);  check_output("lit_reset_hold",  int'(tx_cmd), 0);
    wait_cyc(16);  check_output("lit_align_entry", int'(tx_cmd), 1);
                   check_output("lit_lane_single", int'(lane_en), 4'b0100);
    wait_cyc(79);  check_output("lit_align_last",  int'(tx_cmd), 1);
    wait_cyc(80);  check_output("lit_verify_entry", int'(tx_cmd), 3);
    wait_cyc(100); lane_select = 2'd1;
    wait_cyc(143); check_output("lit_not_up_yet",  int'(channel_up), 0);
    wait_cyc(144); check_output("lit_ready_cmd",   int'(tx_cmd), 4);
                   check_output("lit_channel_up",  int'(channel_up), 1);
                   check_output("lit_axi_ready",   int'(axi_ready), 1);
                   check_output("lit_lane_held",   int'(lane_en), 4'b0100);
                   check_output("lit_no_bond",     int'(saw_bond), 0);

    // Frame cut off by a receiver reset request after two beats.
    wait_cyc(146); axi_valid = 1'b1; axi_last = 1'b0;
    wait_cyc(147); axi_valid = 1'b1; axi_last = 1'b0;
    wait_cyc(148); axi_valid = 1'b0; simplex_reset = 1'b1;
    wait_cyc(149); check_output("lit_abort_pulse", int'(frame_abort), 1);
                   check_output("lit_abort_cmd",   int'(tx_cmd), 0);
                   check_output("lit_abort_ready", int'(axi_ready), 0);
    wait_cyc(150); check_output("lit_abort_once",  int'(frame_abort), 0);
    wait_cyc(155); simplex_reset = 1'b0;
    wait_cyc(170); check_output("lit_reset_held",  int'(tx_cmd), 0);
    wait_cyc(171); check_output("lit_realign",     int'(tx_cmd), 1);
                   check_output("lit_lane_relatch", int'(lane_en), 4'b0010);

    // All lanes bonded; bond reported 10 cycles into BOND.
    do_reset(1'b0, 0, 1'b1, 1'b0, 1'b1);
    wait_cyc(80);  check_output("lit_bond_entry",  int'(tx_cmd), 2);
                   check_output("lit_lane_all",    int'(lane_en), 4'b1111);
    wait_cyc(89);  check_output("lit_bond_last",   int'(tx_cmd), 2);
                   simplex_bonded = 1'b1;
    wait_cyc(90);  check_output("lit_verify_b",    int'(tx_cmd), 3);
    wait_cyc(153); check_output("lit_verify_b_end", int'(tx_cmd), 3);
    wait_cyc(154); check_output("lit_ready_b",     int'(channel_up), 1);
    wait_cyc(160); simplex_aligned = 1'b0;
    wait_cyc(161); check_output("lit_align_lost",  int'(tx_cmd), 0);
                   simplex_aligned = 1'b1;
    wait_cyc(306); check_output("lit_ready_again", int'(tx_cmd), 4);
    wait_cyc(310);

    // Asynchronous reset between clock edges while READY.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("lit_async_cmd",   int'(tx_cmd), 0);
    check_output("lit_async_ready", int'(axi_ready), 0);
    check_output("lit_async_up",    int'(channel_up), 0);
    check_output("lit_async_lanes", int'(lane_en), 0);
    @(negedge clk);

    // Alignment never reported: watchdog behaviour depends on build.
    do_reset(1'b1, 3, 1'b0, 1'b0, 1'b0);
    wait_cyc(16);  check_output("lit_lane3", int'(lane_en), 4'b1000);
`ifdef AURORA_INIT_TIMEOUT_EN
    wait_cyc(215); check_output("lit_wd_pre",   int'(init_timeout), 0);
    wait_cyc(216); check_output("lit_wd_pulse", int'(init_timeout), 1);
                   check_output("lit_wd_reset", int'(tx_cmd), 0);
    wait_cyc(217); check_output("lit_wd_once",  int'(init_timeout), 0);
`else
    wait_cyc(266); check_output("lit_stay_align", int'(tx_cmd), 1);
                   check_output("lit_no_timeout", int'(saw_timeout), 0);
`endif
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
